// File: rtl/irq_ctrl.sv
// Interrupt aggregator: per-channel synchroniser, polarity, edge/level capture, mask, W1C pending, overflow.
// Optional glitch filter between synchroniser and polarity stage when IRQ_FILTER_EN is defined.
module irq_ctrl #(
    parameter int                 NUM_IRQ       = 4,
    parameter int                 SYNC_STAGES   = 2,
    parameter logic [NUM_IRQ-1:0] INIT          = '0,
    parameter int                 FILTER_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] irq_pol,
    input  logic [NUM_IRQ-1:0] irq_edge,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic [NUM_IRQ-1:0] irq_clr,
    output logic [NUM_IRQ-1:0] irq_pend,
    output logic [NUM_IRQ-1:0] irq_ovf,
    output logic [NUM_IRQ-1:0] intr,
    output logic               intr_any
);

    // FILTER_CYCLES only shapes hardware when the filter is built in.
    logic unused_filter_cfg;
    assign unused_filter_cfg = (FILTER_CYCLES == 0);

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   sync_out;
        logic                   filt;
        logic                   act;
        logic                   ev;
        logic                   act_prev_q;
        logic                   pend_q;
        logic                   ovf_q;
        logic                   intr_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) sync_q <= {SYNC_STAGES{INIT[i]}};
            else        sync_q <= {sync_q[SYNC_STAGES-2:0], irq_in[i]};
        end
        assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef IRQ_FILTER_EN
        logic       filt_q;
        logic [7:0] cnt_q;

        // Counter tracks consecutive cycles of disagreement; any agreement restarts it.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                filt_q <= INIT[i];
                cnt_q  <= '0;
            end else if (sync_out == filt_q) begin
                cnt_q  <= '0;
            end else if (cnt_q == 8'(FILTER_CYCLES - 1)) begin
                filt_q <= sync_out;
                cnt_q  <= '0;
            end else begin
                cnt_q  <= cnt_q + 8'd1;
            end
        end
        assign filt = filt_q;
`else
        assign filt = sync_out;
`endif

        assign act = filt ^ irq_pol[i];
        assign ev  = act & ~act_prev_q & irq_edge[i];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                act_prev_q <= 1'b0;
                pend_q     <= 1'b0;
                ovf_q      <= 1'b0;
                intr_q     <= 1'b0;
            end else begin
                act_prev_q <= act;
                intr_q     <= pend_q & irq_mask[i];
                if (irq_edge[i]) begin
                    // A new event wins over a same-cycle clear so it is never lost.
                    pend_q <= ev | (pend_q & ~irq_clr[i]);
                    ovf_q  <= irq_clr[i] ? 1'b0 : (ovf_q | (ev & pend_q));
                end else begin
                    pend_q <= act;
                    ovf_q  <= 1'b0;
                end
            end
        end

        assign irq_pend[i] = pend_q;
        assign irq_ovf[i]  = ovf_q;
        assign intr[i]     = intr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) intr_any <= 1'b0;
        else        intr_any <= |(irq_pend & irq_mask);
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: a cycle-level reference model pushes expected outputs each clock,
// a negedge monitor pops and compares; directed scenarios plus a randomized phase.
module tb_irq_ctrl;
    localparam int N  = 4;
    localparam int S  = 2;
    localparam logic [N-1:0] INIT_V = 4'b1010;
    localparam int FC = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] irq_in, irq_pol, irq_edge, irq_mask, irq_clr;
    logic [N-1:0] irq_pend, irq_ovf, intr;
    logic         intr_any;

    irq_ctrl #(.NUM_IRQ(N), .SYNC_STAGES(S), .INIT(INIT_V), .FILTER_CYCLES(FC)) dut (
        .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .irq_pol(irq_pol), .irq_edge(irq_edge),
        .irq_mask(irq_mask), .irq_clr(irq_clr), .irq_pend(irq_pend), .irq_ovf(irq_ovf),
        .intr(intr), .intr_any(intr_any)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] pend;
        logic [N-1:0] ovf;
        logic [N-1:0] intr;
        logic         any;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [N-1:0] m_hist[$];
    logic [N-1:0] m_filt, m_act_prev, m_pend, m_ovf, m_intr;
    logic         m_any;
    int           m_run[N];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_hist.delete();
        for (int k = 0; k < S; k++) m_hist.push_back(INIT_V);
        m_filt = INIT_V;
        m_act_prev = '0; m_pend = '0; m_ovf = '0; m_intr = '0; m_any = 1'b0;
        for (int c = 0; c < N; c++) m_run[c] = 0;
    endtask

    task automatic model_step();
        logic [N-1:0] sync_now, filt_now, act, ev;
        exp_t e;
        sync_now = m_hist[0];
`ifdef IRQ_FILTER_EN
        filt_now = m_filt;
`else
        filt_now = sync_now;
`endif
        act = filt_now ^ irq_pol;
        ev  = act & ~m_act_prev & irq_edge;
        m_intr = m_pend & irq_mask;
        m_any  = |m_intr;
        for (int c = 0; c < N; c++) begin
            if (irq_edge[c]) begin
                if (ev[c]) begin
                    if (m_pend[c] && !irq_clr[c]) m_ovf[c] = 1'b1;
                    if (irq_clr[c]) m_ovf[c] = 1'b0;
                    m_pend[c] = 1'b1;
                end else if (irq_clr[c]) begin
                    m_pend[c] = 1'b0;
                    m_ovf[c]  = 1'b0;
                end
            end else begin
                m_pend[c] = act[c];
                m_ovf[c]  = 1'b0;
            end
`ifdef IRQ_FILTER_EN
            if (sync_now[c] != m_filt[c]) begin
                m_run[c]++;
                if (m_run[c] == FC) begin
                    m_filt[c] = sync_now[c];
                    m_run[c]  = 0;
                end
            end else begin
                m_run[c] = 0;
            end
`endif
        end
        m_act_prev = act;
        m_hist.push_back(irq_in);
        void'(m_hist.pop_front());
        e.pend = m_pend; e.ovf = m_ovf; e.intr = m_intr; e.any = m_any;
        sb.push_back(e);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
                sb.delete();
            end else begin
                model_step();
            end
        end
    end

    // Monitor: compares whatever the model has queued for the edge just taken.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_pend", 32'(irq_pend), 32'(e.pend));
                chk("sb_ovf",  32'(irq_ovf),  32'(e.ovf));
                chk("sb_intr", 32'(intr),     32'(e.intr));
                chk("sb_any",  32'(intr_any), 32'(e.any));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        irq_in   = '0;
        irq_clr  = '0;
        irq_pol  = '0;
        irq_edge = '1;
        irq_mask = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        repeat (4) tick();
        irq_clr = '1;
        tick();
        irq_clr = '0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        irq_in = '0; irq_pol = '0; irq_edge = '1; irq_mask = '1; irq_clr = '0;
        #1;
        chk("rst_pend", 32'(irq_pend), 0);
        chk("rst_ovf",  32'(irq_ovf),  0);
        chk("rst_intr", 32'(intr),     0);
        chk("rst_any",  32'(intr_any), 0);
        do_reset();

        // Edge latency on channel 0
        irq_in[0] = 1'b1;
        tick(); tick();
        chk("lat_pend_early", 32'(irq_pend[0]), 0);
        tick();
        chk("lat_pend", 32'(irq_pend[0]), 1);
        chk("lat_intr_early", 32'(intr[0]), 0);
        tick();
        chk("lat_intr", 32'(intr[0]), 1);
        chk("lat_any", 32'(intr_any), 1);

        // Overflow then W1C
        irq_in[0] = 1'b0; repeat (3) tick();
        irq_in[0] = 1'b1; repeat (3) tick();
        chk("ovf_set", 32'(irq_ovf[0]), 1);
        irq_clr[0] = 1'b1; tick(); irq_clr[0] = 1'b0;
        chk("clr_pend", 32'(irq_pend[0]), 0);
        chk("clr_ovf",  32'(irq_ovf[0]),  0);

        // Event coincident with clear
        irq_in[0] = 1'b0; repeat (3) tick();
        irq_in[0] = 1'b1; repeat (4) tick();
        irq_in[0] = 1'b0; repeat (3) tick();
        irq_in[0] = 1'b1; tick(); tick();
        irq_clr[0] = 1'b1; tick(); irq_clr[0] = 1'b0;
        chk("coin_pend", 32'(irq_pend[0]), 1);
        chk("coin_ovf",  32'(irq_ovf[0]),  0);
        chk("coin_any",  32'(intr_any),    1);

        // Level mode, active-low source on channel 1
        irq_edge[1] = 1'b0; irq_pol[1] = 1'b1; irq_in[1] = 1'b1;
        repeat (4) tick();
        chk("lvl_idle", 32'(irq_pend[1]), 0);
        irq_in[1] = 1'b0;
        tick(); tick();
        chk("lvl_early", 32'(irq_pend[1]), 0);
        tick();
        chk("lvl_on", 32'(irq_pend[1]), 1);
        repeat (7) tick();
        irq_clr[1] = 1'b1; tick(); irq_clr[1] = 1'b0;
        chk("lvl_clr_ign", 32'(irq_pend[1]), 1);
        chk("lvl_ovf", 32'(irq_ovf[1]), 0);
        repeat (9) tick();
        irq_in[1] = 1'b1;
        tick(); tick();
        chk("lvl_hold", 32'(irq_pend[1]), 1);
        tick();
        chk("lvl_off", 32'(irq_pend[1]), 0);

        // Masked channel, then unmask, then async reset while pending
        irq_mask[2] = 1'b0; irq_in[2] = 1'b1;
        repeat (4) tick();
        chk("msk_pend", 32'(irq_pend[2]), 1);
        chk("msk_intr", 32'(intr[2]), 0);
        irq_mask[2] = 1'b1; tick();
        chk("unmsk_intr", 32'(intr[2]), 1);
        rst_n = 1'b0;
        #1;
        chk("async_pend", 32'(irq_pend), 0);
        chk("async_ovf",  32'(irq_ovf),  0);
        chk("async_intr", 32'(intr),     0);
        chk("async_any",  32'(intr_any), 0);
        do_reset();

`ifdef IRQ_FILTER_EN
        irq_in[0] = 1'b1; repeat (3) tick();
        irq_in[0] = 1'b0; repeat (10) tick();
        chk("flt_glitch", 32'(irq_pend[0]), 0);
        irq_in[0] = 1'b1;
        repeat (6) tick();
        chk("flt_early", 32'(irq_pend[0]), 0);
        tick();
        chk("flt_pend", 32'(irq_pend[0]), 1);
        irq_in[0] = 1'b0;
        repeat (10) tick();
`endif

        // Randomized phase
        for (int cyc = 0; cyc < 1500; cyc++) begin
            logic [N-1:0] tog, clr;
            for (int c = 0; c < N; c++) begin
                tog[c] = ($urandom_range(0, 3) == 0);
                clr[c] = ($urandom_range(0, 5) == 0);
            end
            irq_in  = irq_in ^ tog;
            irq_clr = clr;
            if ($urandom_range(0, 15) == 0) irq_mask = N'($urandom);
            if ($urandom_range(0, 59) == 0) begin
                irq_pol  = N'($urandom);
                irq_edge = N'($urandom);
            end
            if (cyc == 700) begin
                irq_clr = '0;
                do_reset();
            end
            tick();
        end
        irq_clr = '0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
